// File: rtl/mux_arb_pkg.sv
// Shared types and the round-robin search used by the muxed arbiter.
// rr_pick handles up to MAX_N requesters; callers zero-extend their valid vector.
package mux_arb_pkg;

   localparam int unsigned MAX_N    = 32;
   localparam int unsigned MAX_IDXW = 5;

   typedef enum logic {
      ARB_IDLE   = 1'b0,
      ARB_LOCKED = 1'b1
   } arb_state_e;

   // First set bit of valid searching from ptr upward, wrapping modulo n (n need not be 2^k).
   function automatic int unsigned rr_pick(input logic [MAX_N-1:0] valid,
                                           input int unsigned      ptr,
                                           input int unsigned      n);
      int unsigned idx;
      int unsigned pick;
      logic        found;
      pick  = 0;
      found = 1'b0;
      for (int unsigned k = 0; k < MAX_N; k++) begin
         idx = ptr + k;
         if (idx >= n) idx = idx - n;
         if (!found && (k < n) && valid[idx[MAX_IDXW-1:0]]) begin
            pick  = idx;
            found = 1'b1;
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/Mux.sv
// Plain N-input WIDTH-bit multiplexer selected by index.
module Mux #(
   parameter int WIDTH = 8,
   parameter int N     = 4
) (
   input  logic [WIDTH-1:0]       in_data [N-1:0],
   input  logic [$clog2(N)-1:0]   sel,
   output logic [WIDTH-1:0]       out_data
);

   assign out_data = in_data[sel];

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing one Mux between N valid/ready requesters, with burst
// locking and a single registered output stage.
module mux_rr_arbiter
   import mux_arb_pkg::*;
#(
   parameter int  WIDTH = 8,
   parameter int  N     = 4,
   localparam int SELW  = $clog2(N)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N-1:0]     req_valid,
   input  logic [N-1:0]     req_last,
   input  logic [WIDTH-1:0] req_data [N-1:0],
   output logic [N-1:0]     req_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic             out_last,
   output logic [SELW-1:0]  out_sel,
   input  logic             out_ready,
   output logic             busy
);

   // Handshake: a beat moves on port i when req_valid[i] && req_ready[i]; the output
   // beat is consumed when out_valid && out_ready. req_ready never depends on req_ready.

   arb_state_e       state_q, state_d;
   logic [SELW-1:0]  lock_idx_q, lock_idx_d;
   logic [SELW-1:0]  ptr_q, ptr_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic             out_last_q, out_last_d;
   logic [SELW-1:0]  out_sel_q, out_sel_d;

   logic [MAX_N-1:0] valid_ext;
   logic [SELW-1:0]  pick;
   logic [SELW-1:0]  gidx;
   logic             gvalid;
   logic             adv;
   logic             locked;
   logic             xfer;
   logic [WIDTH-1:0] mux_out;

   Mux #(WIDTH, N) u_mux (
      .in_data  (req_data),
      .sel      (gidx),
      .out_data (mux_out)
   );

   always_comb begin
      valid_ext          = '0;
      valid_ext[N-1:0]   = req_valid;
      pick               = SELW'(rr_pick(valid_ext, 32'(ptr_q), N));
      locked             = (state_q == ARB_LOCKED);
      gidx               = locked ? lock_idx_q : pick;
      gvalid             = locked ? req_valid[gidx] : |req_valid;
      adv                = !out_valid_q || out_ready;
      req_ready          = '0;
      // Gated by rst_n so nothing appears ready while the block is held in reset.
      if (rst_n && gvalid && adv) req_ready[gidx] = 1'b1;
      xfer               = |req_ready;
   end

   always_comb begin
      state_d     = state_q;
      lock_idx_d  = lock_idx_q;
      ptr_d       = ptr_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_last_d  = out_last_q;
      out_sel_d   = out_sel_q;
      if (xfer) begin
         out_valid_d = 1'b1;
         out_data_d  = mux_out;
         out_last_d  = req_last[gidx];
         out_sel_d   = gidx;
         if (req_last[gidx]) begin
            state_d = ARB_IDLE;
            ptr_d   = (gidx == SELW'(N-1)) ? '0 : gidx + SELW'(1);
         end else begin
            state_d    = ARB_LOCKED;
            lock_idx_d = gidx;
         end
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ARB_IDLE;
         lock_idx_q  <= '0;
         ptr_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
         out_sel_q   <= '0;
      end else begin
         state_q     <= state_d;
         lock_idx_q  <= lock_idx_d;
         ptr_q       <= ptr_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_last_q  <= out_last_d;
         out_sel_q   <= out_sel_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_last  = out_last_q;
   assign out_sel   = out_sel_q;
   assign busy      = (state_q == ARB_LOCKED);

endmodule

// File: doc/mux_rr_arbiter.md
Name: mux_rr_arbiter

Overview:
- Shares one WIDTH-bit, N-input Mux between N requesters using a round-robin arbiter with valid/ready handshakes on every port.
- Supports multi-beat bursts: a requester keeps the grant until its beat with last=1 is transferred.
- Output is a single registered stage, so the downstream consumer sees clean timing.
- Sits in front of any shared datapath (bus, FIFO write port) that was previously fed by a free-running select counter.

Parameters:
- WIDTH, 8, data width per requester.
- N, 4, number of requesters; any value >= 2, power of two not required.
- SELW, $clog2(N), select width; derived, not overridden.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  N  per-requester valid.
- req_last  in  N  per-requester last-beat flag, qualified by req_valid.
- req_data  in  N x WIDTH  per-requester data (unpacked array [N-1:0]).
- req_ready  out  N  per-requester ready, one-hot or zero.
- out_valid  out  1  registered output valid.
- out_data  out  WIDTH  registered output data.
- out_last  out  1  registered last flag.
- out_sel  out  SELW  index of the requester whose beat is on out_data.
- out_ready  in  1  downstream ready.
- busy  out  1  high while a burst holds the grant (locked).

Behaviour:
- Reset (async on rst_n low): out_valid=0, out_data=0, out_last=0, out_sel=0, locked=0, lock_idx=0, ptr=0. req_ready is combinational and evaluates to 0 during reset.
- Definitions:
  - adv = !out_valid || out_ready (output stage can load).
  - gidx = lock_idx if locked; otherwise the first i in ptr, ptr+1, ..., N-1, 0, ..., ptr-1 with req_valid[i]=1. Modulo N wrap is explicit and correct for non-power-of-2 N.
  - gvalid = req_valid[gidx] if locked; otherwise OR of req_valid.
- req_ready[i] = gvalid && adv && (i == gidx). req_ready is combinational from the inputs; there is no combinational path from req_ready back into any req_* input.
- Transfer on req i occurs when req_valid[i] && req_ready[i]. In the same clock edge:
  - out_data <= Mux(req_data, gidx); out_last <= req_last[i]; out_sel <= i; out_valid <= 1.
  - If req_last[i]=0: locked <= 1, lock_idx <= i.
  - If req_last[i]=1: locked <= 0, ptr <= (i == N-1) ? 0 : i+1.
- No transfer and out_ready=1: out_valid <= 0; out_data, out_sel and out_last hold.
- out_valid=1 and out_ready=0: every output register holds and all req_ready are 0 (backpressure).
- Latency is one cycle from transfer to out_valid. Throughput is 1 beat/cycle with out_ready held high.
- Single-beat requests (last=1) rotate fairly. Each requester is served at most once per N grants while others are pending.
- Locked, grantee drops req_valid: the grant holds and other requesters stall; there is no timeout. Requesters must complete their bursts.
- When locked, other requesters' valids are ignored regardless of ptr.
- ptr advances only when last=1 is transferred.
- rst_n asserted mid-burst: the lock is dropped and the pending output beat is discarded. After reset release, arbitration restarts from ptr=0.
- busy = locked.

Decomposition:
- Shared package mux_arb_pkg:
  - typedef arb_state_e {ARB_IDLE, ARB_LOCKED}; locked is encoded as state == ARB_LOCKED.
  - Function rr_pick(valid, ptr, n) returning the first-set index searching from ptr with modulo wrap.
- Data selection instantiates the existing Mux #(WIDTH, N) as the single sub-module, with sel = gidx. No other sub-modules.

Test Plan:
- Single beats, all valid, out_ready=1, N=4, data[i]=8'h10+i, last=1 → out_sel sequence 0,1,2,3,0,...; out_data 10,11,12,13; one beat per cycle.
- Burst: req1 sends 3 beats AA,AB,AC (last on AC) while req0 and req2 are valid → out shows AA,AB,AC with sel=1 and busy=1 for the first two transfers; the next grant goes to req2; req0 is served after req2.
- Backpressure: out_ready=0 for 5 cycles with out_valid=1 → out_data stable, req_ready=0; on release, the next beat lands the cycle after.
- Wrap with N=3: only req2 and req0 valid, ptr=2 → order 2,0,2,0; no index 3 ever appears on out_sel.
- Async reset mid-burst (rst_n low between clock edges after req3's first beat) → out_valid=0 and busy=0 immediately; after release with all valid, first grant is 0.
- Locked grantee drops valid for 4 cycles while req0 is valid → no transfers, busy=1; when req2 resumes with last=1, the burst completes, then req3 is granted if valid, else req0.
